// File: rtl/triangle_list_ctrl.sv
// triangle_list_ctrl: arbitrates two triangle producers into a triangle list and feeds a rasterizer from it.
// Ports: Clk/Reset_n (async active-low); p0_*/p1_* producer valid/tri/last/ready;
// tl_* list write (w_en, triangle_in), read (r_en, triangle_out) and status (is_empty, is_full);
// c_valid/c_tri/c_ready rasterizer handshake; frame_start/frame_done/busy/tri_count frame control.
module triangle_list_ctrl #(
  parameter int WI = 2,
  parameter int WF = 2
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             p0_valid,
  input  logic [2:0][2:0][WI+WF-1:0]       p0_tri,
  input  logic                             p0_last,
  output logic                             p0_ready,
  input  logic                             p1_valid,
  input  logic [2:0][2:0][WI+WF-1:0]       p1_tri,
  input  logic                             p1_last,
  output logic                             p1_ready,
  output logic                             tl_w_en,
  output logic [2:0][2:0][WI+WF-1:0]       tl_triangle_in,
  output logic                             tl_r_en,
  input  logic [2:0][2:0][WI+WF-1:0]       tl_triangle_out,
  input  logic                             tl_is_empty,
  input  logic                             tl_is_full,
  output logic                             c_valid,
  output logic [2:0][2:0][WI+WF-1:0]       c_tri,
  input  logic                             c_ready,
  input  logic                             frame_start,
  output logic                             frame_done,
  output logic                             busy,
  output logic [15:0]                      tri_count
);
  typedef enum logic [1:0] {R_IDLE, R_POP, R_WAIT, R_HOLD} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, busy_q, busy_d, done0_q, done0_d, done1_q, done1_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0][2:0][WI+WF-1:0] ctri_q, ctri_d;
  logic v0, v1, g0, g1, start, fin;
  // A producer is eligible only inside a frame, with list space, before its last triangle.
  assign v0 = busy_q & ~tl_is_full & p0_valid & ~done0_q;
  assign v1 = busy_q & ~tl_is_full & p1_valid & ~done1_q;
  // ptr_q=0 prefers p0; the preference only matters when both are eligible.
  assign g0 = v0 & (~v1 | ~ptr_q);
  assign g1 = v1 & (~v0 | ptr_q);
  assign p0_ready = g0;
  assign p1_ready = g1;
  assign tl_w_en = g0 | g1;
  assign tl_triangle_in = g1 ? p1_tri : p0_tri;
  assign tl_r_en = state_q == R_POP;
  assign c_valid = state_q == R_HOLD;
  assign c_tri = ctri_q;
  assign busy = busy_q;
  assign tri_count = cnt_q;
  assign start = frame_start & ~busy_q;
  assign fin = busy_q & done0_q & done1_q & tl_is_empty & (state_q == R_IDLE);
  assign frame_done = fin;
  always_comb begin
    state_d = state_q;
    ctri_d = ctri_q;
    case (state_q)
      R_IDLE: state_d = tl_is_empty ? R_IDLE : R_POP;
      R_POP:  state_d = R_WAIT;
      R_WAIT: begin
        ctri_d = tl_triangle_out;
        state_d = R_HOLD;
      end
      R_HOLD: state_d = c_ready ? (tl_is_empty ? R_IDLE : R_POP) : R_HOLD;
    endcase
    ptr_d = (g0 | g1) ? g0 : ptr_q;
    busy_d = start | (busy_q & ~fin);
    done0_d = ~start & (done0_q | (g0 & p0_last));
    done1_d = ~start & (done1_q | (g1 & p1_last));
    cnt_d = start ? 16'd0 : (c_valid & c_ready & ~&cnt_q) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= R_IDLE;
      ptr_q <= 1'b0;
      busy_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      cnt_q <= '0;
      ctri_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      busy_q <= busy_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      cnt_q <= cnt_d;
      ctri_q <= ctri_d;
    end
  end
endmodule

// File: tb/tb_triangle_list_ctrl.sv
// tb_triangle_list_ctrl: directed bench for triangle_list_ctrl with a 16-deep list model.
module tb_triangle_list_ctrl;
  localparam int W = 4;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic p0_valid = 1'b0, p0_last = 1'b0, p1_valid = 1'b0, p1_last = 1'b0;
  logic [2:0][2:0][W-1:0] p0_tri = '0, p1_tri = '0, tl_triangle_in, c_tri;
  logic [2:0][2:0][W-1:0] tl_triangle_out = '0;
  logic p0_ready, p1_ready, tl_w_en, tl_r_en, tl_is_empty, tl_is_full, c_valid;
  logic c_ready = 1'b0, frame_start = 1'b0, frame_done, busy, force_full = 1'b0;
  logic [15:0] tri_count;
  logic [2:0][2:0][W-1:0] mem [16];
  logic [3:0] wp = '0, rp = '0;
  logic [4:0] cnt = '0;
  int checks = 0, errors = 0;

  triangle_list_ctrl #(.WI(2), .WF(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .p0_valid(p0_valid), .p0_tri(p0_tri), .p0_last(p0_last), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_tri(p1_tri), .p1_last(p1_last), .p1_ready(p1_ready),
    .tl_w_en(tl_w_en), .tl_triangle_in(tl_triangle_in), .tl_r_en(tl_r_en),
    .tl_triangle_out(tl_triangle_out), .tl_is_empty(tl_is_empty), .tl_is_full(tl_is_full),
    .c_valid(c_valid), .c_tri(c_tri), .c_ready(c_ready),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy), .tri_count(tri_count)
  );

  always #5 Clk = ~Clk;

  assign tl_is_empty = cnt == 5'd0;
  assign tl_is_full = force_full | (cnt == 5'd16);
  always @(posedge Clk) begin
    if (tl_w_en) begin
      mem[wp] <= tl_triangle_in;
      wp <= wp + 4'd1;
    end
    if (tl_r_en) begin
      tl_triangle_out <= mem[rp];
      rp <= rp + 4'd1;
    end
    cnt <= cnt + {4'd0, tl_w_en} - {4'd0, tl_r_en};
  end

  task automatic tick;
    @(negedge Clk);
  endtask

  task automatic start_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send(input bit p, input logic [35:0] t, input bit last, output bit ok);
    ok = 1'b0;
    if (p) begin p1_valid = 1'b1; p1_tri = t; p1_last = last; end
    else begin p0_valid = 1'b1; p0_tri = t; p0_last = last; end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = p ? p1_ready : p0_ready;
      tick();
    end
    p0_valid = 1'b0; p1_valid = 1'b0; p0_last = 1'b0; p1_last = 1'b0;
  endtask

  task automatic wait_done(output bit d);
    d = 1'b0;
    for (int i = 0; i < 80 && !d; i++) begin
      #1 d = frame_done;
      tick();
    end
  endtask

  task automatic wait_cvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = c_valid;
      if (!ok) tick();
    end
  endtask

  task automatic end_frame(output bit ok);
    bit a, b, d;
    c_ready = 1'b1;
    send(1'b0, 36'hE00, 1'b1, a);
    send(1'b1, 36'hE01, 1'b1, b);
    wait_done(d);
    ok = a & b & d;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; p0_valid = 1'b1; frame_start = 1'b1;
    repeat (2) tick();
    #1;
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL rst_c_valid got %b exp 0", c_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (tri_count !== 16'd0) begin errors++; $display("FAIL rst_tri_count got %h exp 0", tri_count); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
    checks++; if ({p0_ready, p1_ready, tl_w_en, tl_r_en} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b exp 0000", {p0_ready, p1_ready, tl_w_en, tl_r_en}); end
    checks++; if (c_tri !== 36'h0) begin errors++; $display("FAIL rst_c_tri got %h exp 0", c_tri); end
    p0_valid = 1'b0; frame_start = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    bit ok;
    c_ready = 1'b0;
    start_frame();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    p0_valid = 1'b1; p0_tri = '1; p0_last = 1'b1;
    #1;
    checks++; if ({p0_ready, tl_w_en} !== 2'b11) begin errors++; $display("FAIL single_grant got %b exp 11", {p0_ready, tl_w_en}); end
    checks++; if (tl_triangle_in !== 36'hF_FFFF_FFFF) begin errors++; $display("FAIL single_wdata got %h exp fffffffff", tl_triangle_in); end
    tick();
    p0_valid = 1'b0; p0_last = 1'b0;
    #1;
    checks++; if ({tl_w_en, tl_r_en} !== 2'b00) begin errors++; $display("FAIL single_idle got %b exp 00", {tl_w_en, tl_r_en}); end
    tick(); #1;
    checks++; if (tl_r_en !== 1'b1) begin errors++; $display("FAIL single_pop got %b exp 1", tl_r_en); end
    tick(); #1;
    checks++; if ({tl_r_en, c_valid} !== 2'b00) begin errors++; $display("FAIL single_wait got %b exp 00", {tl_r_en, c_valid}); end
    tick(); #1;
    checks++; if (c_valid !== 1'b1) begin errors++; $display("FAIL single_c_valid got %b exp 1", c_valid); end
    checks++; if (c_tri !== 36'hF_FFFF_FFFF) begin errors++; $display("FAIL single_c_tri got %h exp fffffffff", c_tri); end
    p0_valid = 1'b1;
    #1;
    checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL single_done0_blocks got %b exp 0", p0_ready); end
    p0_valid = 1'b0; c_ready = 1'b1;
    tick(); #1;
    checks++; if ({c_valid, busy, frame_done} !== 3'b010) begin errors++; $display("FAIL single_after_accept got %b exp 010", {c_valid, busy, frame_done}); end
    checks++; if (tri_count !== 16'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", tri_count); end
    tick();
    send(1'b1, 36'h1_2345_6789, 1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_p1_send got %b exp 1", ok); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_frame_done got %b exp 1", ok); end
    #1;
    checks++; if ({frame_done, busy} !== 2'b00) begin errors++; $display("FAIL single_done_pulse got %b exp 00", {frame_done, busy}); end
    checks++; if (tri_count !== 16'd2) begin errors++; $display("FAIL single_count2 got %0d exp 2", tri_count); end
    tick();
  endtask

  task automatic test_round_robin;
    bit ok, e0;
    int k0 = 0, k1 = 0;
    logic [35:0] exp_d;
    c_ready = 1'b1;
    start_frame();
    for (int c = 0; c < 20 && (k0 < 4 || k1 < 4); c++) begin
      p0_valid = k0 < 4; p0_tri = 36'h10 + k0; p0_last = k0 == 3;
      p1_valid = k1 < 4; p1_tri = 36'h20 + k1; p1_last = k1 == 3;
      #1;
      e0 = ((k0 + k1) % 2) == 0;
      exp_d = e0 ? 36'h10 + k0 : 36'h20 + k1;
      checks++; if ({p0_ready, p1_ready, tl_w_en} !== {e0, ~e0, 1'b1}) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", c, {p0_ready, p1_ready, tl_w_en}, {e0, ~e0, 1'b1}); end
      checks++; if (tl_triangle_in !== exp_d) begin errors++; $display("FAIL rr_wdata%0d got %h exp %h", c, tl_triangle_in, exp_d); end
      if (p0_ready) k0++;
      if (p1_ready) k1++;
      tick();
    end
    p0_valid = 1'b0; p1_valid = 1'b0; p0_last = 1'b0; p1_last = 1'b0;
    checks++; if (k0 + k1 !== 8) begin errors++; $display("FAIL rr_writes got %0d exp 8", k0 + k1); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_frame_done got %b exp 1", ok); end
    #1;
    checks++; if (tri_count !== 16'd8) begin errors++; $display("FAIL rr_count got %0d exp 8", tri_count); end
    tick();
  endtask

  task automatic test_full;
    bit ok;
    c_ready = 1'b1;
    start_frame();
    force_full = 1'b1; p0_valid = 1'b1; p0_tri = 36'hABC; p0_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({p0_ready, tl_w_en} !== 2'b00) begin errors++; $display("FAIL full_block%0d got %b exp 00", i, {p0_ready, tl_w_en}); end
      tick();
    end
    force_full = 1'b0;
    #1;
    checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL full_resume got %b exp 1", p0_ready); end
    checks++; if (tl_triangle_in !== 36'hABC) begin errors++; $display("FAIL full_held_data got %h exp abc", tl_triangle_in); end
    tick();
    p0_valid = 1'b0;
    end_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_end_frame got %b exp 1", ok); end
    #1;
    checks++; if (tri_count !== 16'd3) begin errors++; $display("FAIL full_count got %0d exp 3", tri_count); end
    tick();
  endtask

  task automatic test_hold;
    bit ok;
    c_ready = 1'b0;
    start_frame();
    p0_valid = 1'b1; p0_tri = 36'h111;
    tick();
    p0_tri = 36'h222;
    #1;
    checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL hold_second_grant got %b exp 1", p0_ready); end
    tick();
    p0_valid = 1'b0;
    wait_cvalid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_c_valid got %b exp 1", ok); end
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks++; if ({c_valid, tl_r_en} !== 2'b10 || c_tri !== 36'h111) begin errors++; $display("FAIL hold_stable%0d got %b/%h exp 10/111", i, {c_valid, tl_r_en}, c_tri); end
    end
    checks++; if (tri_count !== 16'd0) begin errors++; $display("FAIL hold_count0 got %0d exp 0", tri_count); end
    c_ready = 1'b1;
    tick(); #1;
    c_ready = 1'b0;
    checks++; if ({tl_r_en, c_valid} !== 2'b10) begin errors++; $display("FAIL hold_pop_next got %b exp 10", {tl_r_en, c_valid}); end
    checks++; if (tri_count !== 16'd1) begin errors++; $display("FAIL hold_count1 got %0d exp 1", tri_count); end
    tick(); tick(); #1;
    checks++; if (c_valid !== 1'b1 || c_tri !== 36'h222) begin errors++; $display("FAIL hold_second got %b/%h exp 1/222", c_valid, c_tri); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    #1;
    checks++; if ({busy, c_valid} !== 2'b11 || tri_count !== 16'd1) begin errors++; $display("FAIL hold_start_ignored got %b/%0d exp 11/1", {busy, c_valid}, tri_count); end
    c_ready = 1'b1;
    tick(); #1;
    checks++; if (tri_count !== 16'd2 || c_valid !== 1'b0) begin errors++; $display("FAIL hold_count2 got %0d/%b exp 2/0", tri_count, c_valid); end
    tick();
    end_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_end_frame got %b exp 1", ok); end
    #1;
    checks++; if (tri_count !== 16'd4 || busy !== 1'b0) begin errors++; $display("FAIL hold_final got %0d/%b exp 4/0", tri_count, busy); end
    tick();
  endtask

  task automatic test_reset_mid;
    bit ok;
    c_ready = 1'b0;
    start_frame();
    p0_valid = 1'b1; p0_tri = 36'h333;
    tick();
    p0_tri = 36'h444;
    tick();
    p0_valid = 1'b0;
    wait_cvalid(ok);
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;
    wait_cvalid(ok);
    checks++; if (ok !== 1'b1 || c_tri !== 36'h444 || tri_count !== 16'd1) begin errors++; $display("FAIL mid_pre got %b/%h/%0d exp 1/444/1", ok, c_tri, tri_count); end
    Reset_n = 1'b0;
    #1;
    checks++; if ({c_valid, busy} !== 2'b00 || tri_count !== 16'd0 || c_tri !== 36'h0) begin errors++; $display("FAIL mid_async got %b/%0d/%h exp 00/0/0", {c_valid, busy}, tri_count, c_tri); end
    tick();
    Reset_n = 1'b1;
    tick(); #1;
    checks++; if ({c_valid, tl_r_en, busy} !== 3'b000) begin errors++; $display("FAIL mid_release got %b exp 000", {c_valid, tl_r_en, busy}); end
    tick();
    start_frame();
    p0_valid = 1'b1; p0_tri = 36'h555; p1_valid = 1'b1; p1_tri = 36'h666;
    #1;
    checks++; if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL mid_ptr_p0 got %b exp 10", {p0_ready, p1_ready}); end
    tick();
    p0_valid = 1'b0;
    #1;
    checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL mid_p1 got %b exp 1", p1_ready); end
    tick();
    p1_valid = 1'b0;
    end_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_end_frame got %b exp 1", ok); end
    #1;
    checks++; if (tri_count !== 16'd4) begin errors++; $display("FAIL mid_count got %0d exp 4", tri_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/triangle_list_ctrl.md
TRIANGLE_LIST_CTRL -- requirements
Module: triangle_list_ctrl

Interface
REQ-001 SHALL have parameter WI, default 2, integer bits per coordinate.
REQ-002 SHALL have parameter WF, default 2, fraction bits per coordinate; W = WI+WF, triangle T = 3x3xW packed [2:0][2:0][W-1:0] (9*W bits).
REQ-003 SHALL have port Clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port Reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports p0_valid / p1_valid  in  1  producer triangle offered.
REQ-006 SHALL have ports p0_tri / p1_tri  in  T  producer triangle data.
REQ-007 SHALL have ports p0_last / p1_last  in  1  qualifies final triangle of that producer's frame.
REQ-008 SHALL have ports p0_ready / p1_ready  out  1  grant; transfer when valid&ready.
REQ-009 SHALL have ports tl_w_en  out  1, tl_triangle_in  out  T, tl_r_en  out  1  triangle list write/read strobes and data.
REQ-010 SHALL have ports tl_triangle_out  in  T, tl_is_empty  in  1, tl_is_full  in  1  triangle list status and read data.
REQ-011 SHALL have ports c_valid  out  1, c_tri  out  T, c_ready  in  1  rasterizer handshake.
REQ-012 SHALL have ports frame_start  in  1, frame_done  out  1, busy  out  1, tri_count  out  16.

Function
REQ-013 SHALL grant producers only while busy=1 and tl_is_full=0; at most one grant per cycle.
REQ-014 SHALL arbitrate round-robin: pointer selects preferred producer; if only one valid, grant it; after any grant pointer moves to the other producer.
REQ-015 SHALL drive tl_w_en = p0_ready|p1_ready and tl_triangle_in = granted p*_tri combinationally (zero-latency write path, one write per cycle max).
REQ-016 SHALL set sticky done0/done1 when a transfer occurs with p*_last=1; a done producer receives no further grants in the frame.
REQ-017 SHALL run read FSM R_IDLE, R_POP, R_WAIT, R_HOLD.
REQ-018 R_IDLE -> R_POP when tl_is_empty=0; R_POP asserts tl_r_en for exactly one cycle, -> R_WAIT.
REQ-019 R_WAIT: tl_triangle_out valid this cycle (list read latency 1); capture into c_tri at end of cycle, -> R_HOLD.
REQ-020 R_HOLD: c_valid=1, c_tri stable until c_ready=1; on c_ready -> R_POP if tl_is_empty=0 else R_IDLE.
REQ-021 tl_r_en SHALL never assert in any state other than R_POP; read side never blocks write side (simultaneous write and read permitted).
REQ-022 tri_count SHALL increment on each c_valid&c_ready, saturate at 16'hFFFF, clear on accepted frame_start.
REQ-023 frame_start SHALL be accepted only when busy=0: sets busy, clears done0/done1 and tri_count; ignored while busy=1.
REQ-024 frame_done SHALL pulse one cycle when busy & done0 & done1 & tl_is_empty & state=R_IDLE; busy clears in the same edge.
REQ-025 Full boundary: tl_is_full=1 forces both ready=0 regardless of valid; a pending producer holds its data.

Reset
REQ-026 Reset_n=0 SHALL asynchronously force: state R_IDLE, pointer=p0, busy=0, done0=done1=0, tri_count=0, c_valid=0, c_tri=0, frame_done=0.
REQ-027 Reset mid-frame SHALL abandon any held triangle (no consumer transfer) and leave list contents untouched; p*_ready, tl_w_en, tl_r_en are 0 during reset.

Verification
REQ-028 Reset, frame_start, p0_valid only with tri=all-ones, last=1 -> p0_ready same cycle, tl_w_en 1 cycle; tl_r_en 1 cycle later after empty deasserts; c_valid with c_tri=all-ones 2 cycles after tl_r_en.
REQ-029 Both producers valid continuously, 4 triangles each -> grants alternate p0,p1,p0,... starting p0; 8 tl_w_en pulses, no gaps while not full.
REQ-030 tl_is_full=1 held 3 cycles with p0_valid=1 -> p0_ready=0 for those cycles; grant resumes first cycle full=0.
REQ-031 c_ready=0 for 5 cycles in R_HOLD -> c_valid and c_tri stable, no tl_r_en; after c_ready with list non-empty -> R_POP next cycle; tri_count increments once per acceptance.
REQ-032 Both last flags seen, list drains -> frame_done single pulse, busy=0, tri_count=total delivered; frame_start during busy ignored.
REQ-033 Reset_n asserted while R_HOLD -> c_valid=0 immediately (async); after release state R_IDLE, pointer p0, tri_count=0.
